// File: rtl/input_cond_pkg.sv
// Shared definitions for the input conditioner: FSM state encodings and the
// helper that sizes the debounce counter.
package input_cond_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    // Counter width for a debounce length; at least one bit so tiny lengths still elaborate.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_conditioner_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the i_clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_sync;

    // Shift the raw level through the flop chain; all stages clear on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Input conditioner: synchronises and debounces one raw input, producing a
// clean level o_d qualified by o_enable for the downstream enable-gated flop.
// Optional feature macro INPUT_COND_EDGE_EN: when defined, o_rise/o_fall are
// 1-cycle pulses on accepted level changes; otherwise they are tied low.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    input  logic i_run,
    output logic o_d,
    output logic o_enable,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          w_s;
    logic          w_accept;
    logic          r_s_q;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_d;
    logic          r_enable;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_raw),
        .o_sync  (w_s)
    );

    // A new level is taken on the edge where CHANGE has seen the differing level long enough;
    // a low i_run on the same edge overrides it.
    assign w_accept = i_run && (r_state == ST_CHANGE) && (w_s != r_d) && (r_cnt == CNT_MAX);

    // Delayed copy of the synchronised level, used to detect bouncing while settling.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s_q <= 1'b0;
        end else begin
            r_s_q <= w_s;
        end
    end

    // Debounce FSM with counter and registered level/enable outputs; i_run low wins over everything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_d      <= 1'b0;
            r_enable <= 1'b0;
        end else if (!i_run) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_d      <= 1'b0;
            r_enable <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state  <= ST_SETTLE;
                    r_cnt    <= '0;
                    r_d      <= 1'b0;
                    r_enable <= 1'b0;
                end
                ST_SETTLE: begin
                    r_enable <= 1'b0;
                    if (w_s != r_s_q) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state  <= ST_LOCKED;
                        r_d      <= w_s;
                        r_enable <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    r_enable <= 1'b1;
                    if (w_s != r_d) begin
                        r_state <= ST_CHANGE;
                        r_cnt   <= CW'(1);
                    end
                end
                ST_CHANGE: begin
                    r_enable <= 1'b1;
                    if (w_s == r_d) begin
                        // Level went back before the debounce time: glitch rejected.
                        r_state <= ST_LOCKED;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        r_d     <= w_s;
                        r_state <= ST_LOCKED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_d      = r_d;
    assign o_enable = r_enable;

`ifdef INPUT_COND_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Pulse on the edge o_d toggles out of CHANGE; lock-in and IDLE forcing never pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept & w_s;
            r_fall <= w_accept & ~w_s;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Pulse expectations follow INPUT_COND_EDGE_EN.
module tb_input_conditioner;

`ifdef INPUT_COND_EDGE_EN
    localparam logic [31:0] EDGE = 32'd1;
`else
    localparam logic [31:0] EDGE = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic raw;
    logic run;
    logic o_d, o_enable, o_rise, o_fall;

    int n_chk = 0;
    int n_bad = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    input_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_raw    (raw),
        .i_run    (run),
        .o_d      (o_d),
        .o_enable (o_enable),
        .o_rise   (o_rise),
        .o_fall   (o_fall)
    );

    always #5 clk = ~clk;

    // Count pulse cycles mid-period so each 1-cycle pulse is seen once.
    always @(negedge clk) begin
        if (o_rise === 1'b1) rise_cnt++;
        if (o_fall === 1'b1) fall_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int r0, f0;
        bit bad;

        rst_n = 1'b0;
        raw   = 1'b0;
        run   = 1'b0;
        #1;
        check("rst_d", 32'(o_d), 0);
        check("rst_en", 32'(o_enable), 0);
        check("rst_rise", 32'(o_rise), 0);
        check("rst_fall", 32'(o_fall), 0);
        check("rst_state", 32'(dut.r_state), 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // 1: lock-in with steady high input
        raw = 1'b1;
        tick(4);
        r0 = rise_cnt;
        run = 1'b1;
        tick(1);
        check("t1_settle", 32'(dut.r_state), 1);
        tick(3);
        check("t1_en_early", 32'(o_enable), 0);
        tick(1);
        check("t1_en", 32'(o_enable), 1);
        check("t1_d", 32'(o_d), 1);
        tick(2);
        check("t1_no_rise", 32'(rise_cnt - r0), 0);

        // 2: accepted 1->0 change, 6 edges after the raw change
        f0 = fall_cnt;
        bad = 1'b0;
        raw = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            if (o_enable !== 1'b1) bad = 1'b1;
            if (i == 5) check("t2_d_hold", 32'(o_d), 1);
            if (i == 6) begin
                check("t2_d_new", 32'(o_d), 0);
                check("t2_fall", 32'(o_fall), EDGE);
            end
            if (i == 7) check("t2_fall_end", 32'(o_fall), 0);
        end
        check("t2_en_held", 32'(bad), 0);
        check("t2_fall_cnt", 32'(fall_cnt - f0), EDGE);

        // 3: 3-cycle glitch rejected, 4-cycle pulse accepted
        r0 = rise_cnt;
        bad = 1'b0;
        raw = 1'b1;
        tick(3);
        raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (o_d !== 1'b0) bad = 1'b1;
        end
        check("t3_glitch_d", 32'(bad), 0);
        check("t3_locked", 32'(dut.r_state), 2);
        check("t3_no_rise", 32'(rise_cnt - r0), 0);
        raw = 1'b1;
        tick(4);
        raw = 1'b0;
        tick(2);
        check("t3_accept_d", 32'(o_d), 1);
        check("t3_rise", 32'(o_rise), EDGE);
        tick(8);
        check("t3_back_d", 32'(o_d), 0);
        check("t3_rise_cnt", 32'(rise_cnt - r0), EDGE);

        // 5: stop during CHANGE with cnt=2
        raw = 1'b1;
        tick(4);
        check("t5_change", 32'(dut.r_state), 3);
        check("t5_cnt", 32'(dut.r_cnt), 2);
        r0 = rise_cnt;
        f0 = fall_cnt;
        run = 1'b0;
        tick(1);
        check("t5_en", 32'(o_enable), 0);
        check("t5_d", 32'(o_d), 0);
        check("t5_idle", 32'(dut.r_state), 0);
        tick(3);
        check("t5_still_idle", 32'(dut.r_state), 0);
        check("t5_no_pulse", 32'((rise_cnt - r0) + (fall_cnt - f0)), 0);

        // 4: bounce while settling, then steady high
        raw = 1'b0;
        tick(4);
        bad = 1'b0;
        run = 1'b1;
        for (int seg = 0; seg < 10; seg++) begin
            raw = (seg % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                tick(1);
                if (o_enable !== 1'b0) bad = 1'b1;
            end
        end
        raw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (o_enable !== 1'b0) bad = 1'b1;
        end
        check("t4_en_low", 32'(bad), 0);
        tick(1);
        check("t4_en", 32'(o_enable), 1);
        check("t4_d", 32'(o_d), 1);

        // 6: async reset mid-CHANGE, then fresh settle
        raw = 1'b0;
        tick(4);
        check("t6_change", 32'(dut.r_state), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_d", 32'(o_d), 0);
        check("t6_rst_en", 32'(o_enable), 0);
        check("t6_rst_pulse", 32'({o_rise, o_fall}), 0);
        check("t6_rst_state", 32'(dut.r_state), 0);
        #1;
        rst_n = 1'b1;
        tick(1);
        check("t6_settle", 32'(dut.r_state), 1);
        tick(3);
        check("t6_en_early", 32'(o_enable), 0);
        tick(1);
        check("t6_en", 32'(o_enable), 1);
        check("t6_d", 32'(o_d), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
